// File: rtl/cache_sched_pkg.sv
// cache_sched_pkg: shared types and helpers for the cache access scheduler.
//   state_t  - access sequencing states
//   *_DEF    - default address / counter widths
//   sat_inc  - saturating increment (counters up to 32 bits wide)
package cache_sched_pkg;

    localparam int ADDR_W_DEF = 31;
    localparam int CNT_W_DEF  = 31;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM,
        FILL,
        RESP
    } state_t;

    // Holds at max_v instead of wrapping; callers zero-extend to 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cache_access_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       - request vector
//   ptr       - highest-priority index this round
//   gnt       - one-hot grant (zero when no request)
//   gnt_id    - binary index of the grant
//   any_valid - at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any_valid
);

    localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0] sum;

    // Walk offsets from the farthest to the nearest so the requester
    // closest to ptr (wrapping) is the last, and therefore winning, write.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        sum       = '0;
        any_valid = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= NR) sum = sum - NR;
            if (req[sum[ID_W-1:0]]) begin
                gnt                  = '0;
                gnt[sum[ID_W-1:0]]   = 1'b1;
                gnt_id               = sum[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cache_access_sched.sv
// cache_access_sched: round-robin sharing of the sector cache lookup port
// between NUM_REQ address-trace requesters. One access is in flight at a
// time: LOOKUP -> CHECK -> (MEM -> FILL on miss) -> RESP.
//
// Ports:
//   clk_41, rst_41        clock / async active-low reset
//   req_valid_41/addr_41  per-requester request, packed addresses
//   req_ready_41          one-hot accept strobe (combinational)
//   resp_*_41             one-cycle response pulse with id and hit flag
//   cache_*_41            lookup strobe, address, hit result, fill strobe
//   mem_*_41              refill request (level), address, ack pulse
//   hits_41, misses_41    saturating global counters
//   req_hits_41           per-requester hit counters, present only when
//                         CACHE_SCHED_PER_REQ_CNT_EN is defined
// CNT_W must not exceed 32.
module cache_access_sched
    import cache_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_41,
    input  logic                      rst_41,
    input  logic [NUM_REQ-1:0]        req_valid_41,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_41,
    output logic [NUM_REQ-1:0]        req_ready_41,
    output logic                      resp_valid_41,
    output logic [ID_W-1:0]           resp_id_41,
    output logic                      resp_hit_41,
    output logic                      cache_lookup_41,
    output logic [ADDR_W-1:0]         cache_addr_41,
    input  logic                      cache_hit_41,
    output logic                      cache_fill_41,
    output logic                      mem_req_41,
    output logic [ADDR_W-1:0]         mem_addr_41,
    input  logic                      mem_ack_41,
    output logic [CNT_W-1:0]          hits_41,
    output logic [CNT_W-1:0]          misses_41
`ifdef CACHE_SCHED_PER_REQ_CNT_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  req_hits_41
`endif
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    state_t                          state;
    logic [ID_W-1:0]                 rr_ptr;
    logic [ADDR_W-1:0]               lat_addr;
    logic [ID_W-1:0]                 lat_id;
    logic [NUM_REQ-1:0]              gnt;
    logic [ID_W-1:0]                 gnt_id;
    logic                            any_valid;
    logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_v;

    assign addr_v = req_addr_41;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req       (req_valid_41),
        .ptr       (rr_ptr),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .any_valid (any_valid)
    );

    // Accept is the only combinational output so a requester sees its grant
    // in the same cycle its address is captured.
    assign req_ready_41 = (state == IDLE) ? gnt : '0;

    always_ff @(posedge clk_41 or negedge rst_41) begin
        if (!rst_41) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            lat_addr        <= '0;
            lat_id          <= '0;
            cache_lookup_41 <= 1'b0;
            cache_addr_41   <= '0;
            cache_fill_41   <= 1'b0;
            mem_req_41      <= 1'b0;
            mem_addr_41     <= '0;
            resp_valid_41   <= 1'b0;
            resp_id_41      <= '0;
            resp_hit_41     <= 1'b0;
            hits_41         <= '0;
            misses_41       <= '0;
        end else begin
            // strobes default low; each is raised for the one state it marks
            cache_lookup_41 <= 1'b0;
            cache_fill_41   <= 1'b0;
            resp_valid_41   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        lat_addr        <= addr_v[gnt_id];
                        lat_id          <= gnt_id;
                        rr_ptr          <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                        cache_lookup_41 <= 1'b1;
                        cache_addr_41   <= addr_v[gnt_id];
                        state           <= LOOKUP;
                    end
                end
                LOOKUP: state <= CHECK;
                CHECK: begin
                    if (cache_hit_41) begin
                        hits_41       <= CNT_W'(sat_inc(32'(hits_41), CNT_MAX));
                        resp_valid_41 <= 1'b1;
                        resp_id_41    <= lat_id;
                        resp_hit_41   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        misses_41     <= CNT_W'(sat_inc(32'(misses_41), CNT_MAX));
                        mem_req_41    <= 1'b1;
                        mem_addr_41   <= lat_addr;
                        state         <= MEM;
                    end
                end
                MEM: begin
                    if (mem_ack_41) begin
                        mem_req_41    <= 1'b0;
                        cache_fill_41 <= 1'b1;
                        cache_addr_41 <= lat_addr;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    resp_valid_41 <= 1'b1;
                    resp_id_41    <= lat_id;
                    resp_hit_41   <= 1'b0;
                    state         <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_SCHED_PER_REQ_CNT_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] req_hits;

    always_ff @(posedge clk_41 or negedge rst_41) begin
        if (!rst_41)
            req_hits <= '0;
        else if (state == CHECK && cache_hit_41)
            req_hits[lat_id] <= CNT_W'(sat_inc(32'(req_hits[lat_id]), CNT_MAX));
    end

    assign req_hits_41 = req_hits;
`else
    // only the global hit/miss counters are kept in this build
`endif

endmodule

// File: tb/tb_cache_access_sched.sv
module tb_cache_access_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [3:0]        req_valid = '0;
    logic [3:0][30:0]  req_addr_v = '0;
    logic [3:0]        req_ready;
    logic              resp_valid, resp_hit, cache_lookup, cache_fill, mem_req;
    logic [1:0]        resp_id;
    logic [30:0]       cache_addr, mem_addr, hits, misses;
    logic              cache_hit = 1'b0, mem_ack = 1'b0;

    // narrow-counter instance: both requesters always valid, every lookup hits
    logic [1:0]        s_valid = 2'b11;
    logic [61:0]       s_addr = '0;
    logic [1:0]        s_ready;
    logic              s_resp_valid, s_resp_hit, s_lookup, s_fill, s_mreq;
    logic [0:0]        s_resp_id;
    logic [30:0]       s_caddr, s_maddr;
    logic              s_chit = 1'b1, s_mack = 1'b0;
    logic [1:0]        s_hits, s_misses;

`ifdef CACHE_SCHED_PER_REQ_CNT_EN
    logic [3:0][30:0]  req_hits_v;
    logic [3:0]        s_req_hits;
    int                m_rhits[4];
`endif

    cache_access_sched #(.NUM_REQ(4), .ADDR_W(31), .CNT_W(31)) dut (
        .clk_41(clk), .rst_41(rst), .req_valid_41(req_valid), .req_addr_41(req_addr_v),
        .req_ready_41(req_ready), .resp_valid_41(resp_valid), .resp_id_41(resp_id),
        .resp_hit_41(resp_hit), .cache_lookup_41(cache_lookup), .cache_addr_41(cache_addr),
        .cache_hit_41(cache_hit), .cache_fill_41(cache_fill), .mem_req_41(mem_req),
        .mem_addr_41(mem_addr), .mem_ack_41(mem_ack), .hits_41(hits), .misses_41(misses)
`ifdef CACHE_SCHED_PER_REQ_CNT_EN
        , .req_hits_41(req_hits_v)
`endif
    );

    cache_access_sched #(.NUM_REQ(2), .ADDR_W(31), .CNT_W(2)) dut_s (
        .clk_41(clk), .rst_41(rst), .req_valid_41(s_valid), .req_addr_41(s_addr),
        .req_ready_41(s_ready), .resp_valid_41(s_resp_valid), .resp_id_41(s_resp_id),
        .resp_hit_41(s_resp_hit), .cache_lookup_41(s_lookup), .cache_addr_41(s_caddr),
        .cache_hit_41(s_chit), .cache_fill_41(s_fill), .mem_req_41(s_mreq),
        .mem_addr_41(s_maddr), .mem_ack_41(s_mack), .hits_41(s_hits), .misses_41(s_misses)
`ifdef CACHE_SCHED_PER_REQ_CNT_EN
        , .req_hits_41(s_req_hits)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int m_ptr = 0;
    int m_hits = 0;
    int m_misses = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference arbitration: first valid index at or after the pointer, wrapping
    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (v[idx[1:0]]) return idx;
        end
        return 0;
    endfunction

    // One complete access starting in IDLE; returns in IDLE one cycle after RESP.
    task automatic do_access(input logic [3:0] v, input logic [30:0] a, input bit hit,
                             input int dly, input int id);
        for (int k = 0; k < 4; k++) req_addr_v[k] = 31'($urandom);
        req_addr_v[id[1:0]] = a;
        req_valid = v;
        cache_hit = 1'b0;
        mem_ack   = 1'b0;
        #1;
        chk("grant_onehot", 64'(req_ready), 64'(4'b0001 << id));
        m_ptr = (id + 1) % 4;
        @(posedge clk); #1;
        chk("lookup_strobe", 64'(cache_lookup), 64'd1);
        chk("lookup_addr", 64'(cache_addr), 64'(a));
        chk("ready_when_busy", 64'(req_ready), 64'd0);
        cache_hit = ~hit;                       // not in CHECK: must be ignored
        @(posedge clk); #1;
        chk("lookup_one_cycle", 64'(cache_lookup), 64'd0);
        chk("no_early_resp", 64'(resp_valid), 64'd0);
        cache_hit = hit;
        @(posedge clk); #1;
        if (hit) begin
            m_hits++;
            chk("hit_resp_valid", 64'(resp_valid), 64'd1);
            chk("hit_resp_id", 64'(resp_id), 64'(id));
            chk("hit_resp_hit", 64'(resp_hit), 64'd1);
            chk("hits_cnt", 64'(hits), 64'(m_hits));
            chk("misses_cnt", 64'(misses), 64'(m_misses));
`ifdef CACHE_SCHED_PER_REQ_CNT_EN
            m_rhits[id]++;
            chk("req_hits_cnt", 64'(req_hits_v[id[1:0]]), 64'(m_rhits[id]));
`endif
        end else begin
            m_misses++;
            cache_hit = 1'b1;                   // stray hit during refill
            chk("mem_req_rise", 64'(mem_req), 64'd1);
            chk("mem_addr", 64'(mem_addr), 64'(a));
            chk("misses_cnt", 64'(misses), 64'(m_misses));
            chk("hits_cnt", 64'(hits), 64'(m_hits));
            for (int d = 0; d < dly; d++) begin
                @(posedge clk); #1;
                chk("mem_req_held", 64'(mem_req), 64'd1);
                chk("mem_addr_held", 64'(mem_addr), 64'(a));
            end
            mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            chk("mem_req_drop", 64'(mem_req), 64'd0);
            chk("fill_strobe", 64'(cache_fill), 64'd1);
            chk("fill_addr", 64'(cache_addr), 64'(a));
            chk("no_resp_in_fill", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
            chk("fill_one_cycle", 64'(cache_fill), 64'd0);
            chk("miss_resp_valid", 64'(resp_valid), 64'd1);
            chk("miss_resp_id", 64'(resp_id), 64'(id));
            chk("miss_resp_hit", 64'(resp_hit), 64'd0);
            cache_hit = 1'b0;
        end
        @(posedge clk); #1;
        chk("resp_one_cycle", 64'(resp_valid), 64'd0);
        chk("resp_id_hold", 64'(resp_id), 64'(id));
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [30:0] addr;
        bit          hit;
        int          dly;
        int          id;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sv;
        bit          found;

        tbl[0]  = '{4'b0100, 31'h100,  1'b1, 0, 2};
        tbl[1]  = '{4'b0001, 31'h2040, 1'b0, 4, 0};
        tbl[2]  = '{4'b1001, 31'h3a0,  1'b1, 0, 3};
        tbl[3]  = '{4'b1111, 31'h1000, 1'b1, 0, 0};
        tbl[4]  = '{4'b1111, 31'h1004, 1'b0, 2, 1};
        tbl[5]  = '{4'b1111, 31'h1008, 1'b1, 0, 2};
        tbl[6]  = '{4'b1111, 31'h100c, 1'b1, 0, 3};
        tbl[7]  = '{4'b1111, 31'h1010, 1'b0, 0, 0};
        tbl[8]  = '{4'b1111, 31'h1014, 1'b1, 0, 1};
        tbl[9]  = '{4'b1111, 31'h1018, 1'b1, 0, 2};
        tbl[10] = '{4'b1111, 31'h101c, 1'b0, 1, 3};
        tbl[11] = '{4'b0011, 31'h7fff_fff0, 1'b0, 1, 0};
        tbl[12] = '{4'b0101, 31'h0,    1'b1, 0, 2};
        tbl[13] = '{4'b0001, 31'h4444, 1'b0, 0, 0};
        tbl[14] = '{4'b1110, 31'h5a5a, 1'b1, 0, 1};
`ifdef CACHE_SCHED_PER_REQ_CNT_EN
        for (int k = 0; k < 4; k++) m_rhits[k] = 0;
`endif

        // reset state
        #1 rst = 1'b0;
        #3;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_lookup", 64'(cache_lookup), 64'd0);
        chk("rst_cache_addr", 64'(cache_addr), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_resp", 64'({resp_valid, resp_id, resp_hit}), 64'd0);
        chk("rst_hits", 64'(hits), 64'd0);
        chk("rst_misses", 64'(misses), 64'd0);
        #8 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++)
            do_access(tbl[i].valid, tbl[i].addr, tbl[i].hit, tbl[i].dly, tbl[i].id);

        // stray mem_ack / cache_hit while idle
        req_valid = '0;
        mem_ack   = 1'b1;
        cache_hit = 1'b1;
        #1;
        chk("idle_no_grant", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        cache_hit = 1'b0;
        chk("stray_lookup", 64'(cache_lookup), 64'd0);
        chk("stray_mem_req", 64'(mem_req), 64'd0);
        chk("stray_fill", 64'(cache_fill), 64'd0);
        chk("stray_resp", 64'(resp_valid), 64'd0);
        chk("stray_hits", 64'(hits), 64'(m_hits));
        chk("stray_misses", 64'(misses), 64'(m_misses));

        // reset in the middle of a refill
        do_access(4'b0010, 31'h2222, 1'b1, 0, 1);
        req_valid     = 4'b0100;
        req_addr_v[2] = 31'h3000;
        #1;
        chk("mid_grant", 64'(req_ready), 64'd4);
        @(posedge clk); #1;
        cache_hit = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_mem_req", 64'(mem_req), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_mem_req", 64'(mem_req), 64'd0);
        chk("mid_rst_misses", 64'(misses), 64'd0);
        chk("mid_rst_hits", 64'(hits), 64'd0);
        chk("mid_rst_cache_addr", 64'(cache_addr), 64'd0);
        req_valid = '0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        m_ptr = 0; m_hits = 0; m_misses = 0;
`ifdef CACHE_SCHED_PER_REQ_CNT_EN
        for (int k = 0; k < 4; k++) m_rhits[k] = 0;
`endif
        do_access(4'b1111, 31'h5555, 1'b1, 0, 0);

        // randomized accesses against the transaction-level model
        for (int r = 0; r < 40; r++) begin
            logic [3:0] v;
            v = 4'($urandom_range(1, 15));
            do_access(v, 31'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      model_grant(v, m_ptr));
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                @(posedge clk); #1;
                chk("gap_ready", 64'(req_ready), 64'd0);
                chk("gap_lookup", 64'(cache_lookup), 64'd0);
            end
        end

        // counter saturation on the 2-bit-counter instance
        req_valid = '0;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            found = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (s_resp_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("sat_resp_seen", 64'(found), 64'd1);
            chk("sat_hits", 64'(s_hits), 64'((i + 1 > 3) ? 3 : i + 1));
            chk("sat_misses", 64'(s_misses), 64'd0);
            chk("sat_rr_id", 64'(s_resp_id), 64'(i % 2));
        end

        sv = 32'h7FFF_FFFE;
        repeat (3) sv = cache_sched_pkg::sat_inc(sv, 32'h7FFF_FFFF);
        chk("pkg_sat_inc", 64'(sv), 64'h7FFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
